// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet framing constants, CRC32 constants and receive parser state type
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam int          ETH_HDR_LEN   = 14;
    localparam int          ETH_FCS_LEN   = 4;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEAD,
        ST_PAYLOAD,
        ST_WAIT_END
    } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational CRC32 next state for one byte, data LSB first
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[31] ^ data[i]) begin
                crc_next = {crc_next[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                crc_next = {crc_next[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/eth_rx_frame_parser.sv
// rtl/eth_rx_frame_parser.sv - GMII receive parser: preamble strip, MAC filter, payload delivery, FCS check
module eth_rx_frame_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC    = 48'h00_11_22_33_44_55,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int          MAX_LEN      = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [7:0]  rec_data,
    output logic        rec_sof,
    output logic        rec_pkt_done,
    output logic        rec_crc_err,
    output logic [15:0] rec_byte_num,
    output logic        rec_drop,
    output logic [47:0] src_mac,
    output logic [15:0] eth_type
);

    localparam logic [15:0] HDR_LAST = 16'(ETH_HDR_LEN - 1);
    localparam logic [15:0] FCS_LEN  = 16'(ETH_FCS_LEN);
    localparam logic [15:0] LEN_MAX  = 16'(MAX_LEN);

    rx_state_t     state, state_next;
    logic          dv_r;
    logic [7:0]    rxd_r;
    logic [3:0]    pre_cnt;
    logic [15:0]   byte_cnt;
    logic [15:0]   pay_cnt;
    logic [103:0]  hdr;
    logic [111:0]  hdr_next;
    logic [31:0]   dly;
    logic [31:0]   crc;
    logic [31:0]   crc_calc;
    logic          dest_ok;
    logic          pre_inc;
    logic          crc_upd;
    logic          hdr_accept;
    logic          frame_end;
    logic          len_drop;
    logic          emit;

    // Header decision uses the byte arriving this cycle, so look one byte ahead.
    assign hdr_next = {hdr, rxd_r};
    assign dest_ok  = (hdr_next[111:64] == BOARD_MAC) ||
                      (ACCEPT_BCAST && (&hdr_next[111:64]));

    crc32_d8 u_crc (
        .crc      (crc),
        .data     (rxd_r),
        .crc_next (crc_calc)
    );

    always_comb begin
        state_next = state;
        pre_inc    = 1'b0;
        crc_upd    = 1'b0;
        hdr_accept = 1'b0;
        frame_end  = 1'b0;
        len_drop   = 1'b0;
        emit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dv_r && rxd_r == ETH_PREAMBLE) state_next = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (!dv_r) begin
                    state_next = ST_IDLE;
                end else if (rxd_r == ETH_PREAMBLE) begin
                    pre_inc = 1'b1;
                end else if (rxd_r == ETH_SFD && pre_cnt >= 4'd6) begin
                    state_next = ST_HEAD;
                end else begin
                    state_next = ST_WAIT_END;
                end
            end
            ST_HEAD: begin
                if (!dv_r) begin
                    state_next = ST_IDLE;
                end else begin
                    crc_upd = 1'b1;
                    if (byte_cnt == HDR_LAST) begin
                        hdr_accept = dest_ok;
                        state_next = dest_ok ? ST_PAYLOAD : ST_WAIT_END;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!dv_r) begin
                    frame_end  = 1'b1;
                    state_next = ST_IDLE;
                end else if (byte_cnt >= LEN_MAX) begin
                    len_drop   = 1'b1;
                    state_next = ST_WAIT_END;
                end else begin
                    crc_upd = 1'b1;
                    emit    = (pay_cnt >= FCS_LEN);
                end
            end
            ST_WAIT_END: begin
                if (!dv_r) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dv_r         <= 1'b0;
            rxd_r        <= 8'h00;
            pre_cnt      <= 4'd0;
            byte_cnt     <= 16'd0;
            pay_cnt      <= 16'd0;
            hdr          <= '0;
            dly          <= 32'd0;
            crc          <= CRC32_INIT;
            rec_en       <= 1'b0;
            rec_data     <= 8'h00;
            rec_sof      <= 1'b0;
            rec_pkt_done <= 1'b0;
            rec_crc_err  <= 1'b0;
            rec_byte_num <= 16'd0;
            rec_drop     <= 1'b0;
            src_mac      <= 48'd0;
            eth_type     <= 16'd0;
        end else begin
            dv_r         <= gmii_rx_dv;
            rxd_r        <= gmii_rxd;
            state        <= state_next;
            rec_en       <= emit;
            rec_sof      <= emit && (pay_cnt == FCS_LEN);
            rec_pkt_done <= frame_end;
            rec_drop     <= len_drop;
            if (emit) rec_data <= dly[31:24];

            if (state == ST_IDLE) begin
                pre_cnt <= 4'd1;
            end else if (pre_inc && pre_cnt != 4'hF) begin
                pre_cnt <= pre_cnt + 4'd1;
            end

            if (state == ST_PREAMBLE) begin
                crc      <= CRC32_INIT;
                byte_cnt <= 16'd0;
                pay_cnt  <= 16'd0;
            end

            if (crc_upd) begin
                crc      <= crc_calc;
                byte_cnt <= byte_cnt + 16'd1;
            end

            if (state == ST_HEAD && dv_r) hdr <= hdr_next[103:0];

            if (hdr_accept) begin
                src_mac  <= hdr_next[63:16];
                eth_type <= hdr_next[15:0];
            end

            // The newest four bytes may be the FCS, so only the fifth-newest is released.
            if (state == ST_PAYLOAD && crc_upd) begin
                dly     <= {dly[23:0], rxd_r};
                pay_cnt <= pay_cnt + 16'd1;
            end

            if (frame_end) begin
                rec_byte_num <= (pay_cnt >= FCS_LEN) ? pay_cnt - FCS_LEN : 16'd0;
                rec_crc_err  <= (pay_cnt < FCS_LEN) || (crc != CRC32_RESIDUE);
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// tb/tb_eth_rx_frame_parser.sv - self-checking bench for eth_rx_frame_parser
module tb_eth_rx_frame_parser;

    localparam logic [47:0] BOARD = 48'h00_11_22_33_44_55;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;

    logic [2:0]  en, sof, done, err, drop;
    logic [7:0]  data [3];
    logic [15:0] num [3];
    logic [47:0] src [3];
    logic [15:0] typ [3];

    int checks = 0;
    int failures = 0;

    eth_rx_frame_parser u_dut (
        .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .rec_en(en[0]), .rec_data(data[0]), .rec_sof(sof[0]), .rec_pkt_done(done[0]),
        .rec_crc_err(err[0]), .rec_byte_num(num[0]), .rec_drop(drop[0]),
        .src_mac(src[0]), .eth_type(typ[0])
    );

    eth_rx_frame_parser #(.ACCEPT_BCAST(1'b0)) u_nobc (
        .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .rec_en(en[1]), .rec_data(data[1]), .rec_sof(sof[1]), .rec_pkt_done(done[1]),
        .rec_crc_err(err[1]), .rec_byte_num(num[1]), .rec_drop(drop[1]),
        .src_mac(src[1]), .eth_type(typ[1])
    );

    eth_rx_frame_parser #(.MAX_LEN(64)) u_short (
        .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .rec_en(en[2]), .rec_data(data[2]), .rec_sof(sof[2]), .rec_pkt_done(done[2]),
        .rec_crc_err(err[2]), .rec_byte_num(num[2]), .rec_drop(drop[2]),
        .src_mac(src[2]), .eth_type(typ[2])
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge
    int          en_cnt [3];
    int          done_cnt [3];
    int          drop_cnt [3];
    int          sof_cnt [3];
    int          sof_bad;
    logic [15:0] num_l [3];
    logic        err_l [3];
    logic [7:0]  got0 [$];
    int          clr_seq = 0;
    int          clr_seen = 0;

    always @(negedge clk) begin
        if (clr_seen != clr_seq) begin
            clr_seen = clr_seq;
            for (int k = 0; k < 3; k++) begin
                en_cnt[k] = 0; done_cnt[k] = 0; drop_cnt[k] = 0; sof_cnt[k] = 0;
                num_l[k] = 16'hFFFF; err_l[k] = 1'b0;
            end
            sof_bad = 0;
            got0.delete();
        end
        for (int k = 0; k < 3; k++) begin
            if (en[k]) en_cnt[k]++;
            if (sof[k]) sof_cnt[k]++;
            if (drop[k]) drop_cnt[k]++;
            if (done[k]) begin
                done_cnt[k]++;
                num_l[k] = num[k];
                err_l[k] = err[k];
            end
        end
        if (en[0]) begin
            if (sof[0] != (got0.size() == 0)) sof_bad++;
            got0.push_back(data[0]);
        end
    end

    // Reference frame and expectations
    logic [7:0]  body [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  exp_pay [$];
    logic [47:0] exp_src;
    logic [15:0] exp_type;
    int          exp_n;
    int          exp_len;
    bit          exp_bad, exp_acc0, exp_acc1;

    function automatic logic [31:0] ref_fcs();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (body[i]) begin
            c = c ^ {24'h0, body[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input int npre, input logic [47:0] dst, input logic [15:0] et,
                         input int n, input bit inc, input bit bad);
        logic [31:0] f;
        logic [47:0] s;
        logic [7:0]  b;
        s = {16'($urandom), 32'($urandom)};
        body.delete(); exp_pay.delete(); tx_q.delete();
        for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(s[47-8*i -: 8]);
        body.push_back(et[15:8]);
        body.push_back(et[7:0]);
        for (int i = 0; i < n; i++) begin
            b = inc ? 8'(i) : 8'($urandom);
            body.push_back(b);
            exp_pay.push_back(b);
        end
        f = ref_fcs();
        for (int i = 0; i < npre; i++) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        foreach (body[i]) tx_q.push_back(body[i]);
        for (int i = 0; i < 4; i++) tx_q.push_back(8'(f >> (8*i)) ^ ((bad && i == 3) ? 8'h01 : 8'h00));
        exp_src  = s;
        exp_type = et;
        exp_n    = n;
        exp_len  = n + 18;
        exp_bad  = bad;
        exp_acc0 = (dst == BOARD) || (dst == BCAST);
        exp_acc1 = (dst == BOARD);
    endtask

    task automatic drive_byte(input logic dv, input logic [7:0] b);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = b;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive_byte(1'b0, 8'($urandom));
    endtask

    task automatic send(input int gap);
        foreach (tx_q[i]) drive_byte(1'b1, tx_q[i]);
        idle(gap);
    endtask

    task automatic clear_mon();
        clr_seq++;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        int nbad;
        nbad = 0;
        if (got0.size() != exp_pay.size()) nbad = -1;
        else foreach (exp_pay[i]) if (got0[i] !== exp_pay[i]) nbad++;
        if (exp_acc0) begin
            chk({tag, "/done0"}, 64'(done_cnt[0]), 64'd1);
            chk({tag, "/num0"}, 64'(num_l[0]), 64'(exp_n));
            chk({tag, "/err0"}, 64'(err_l[0]), 64'(exp_bad));
            chk({tag, "/data0"}, 64'(nbad), 64'd0);
            chk({tag, "/sof0"}, 64'(sof_cnt[0]), (exp_n > 0) ? 64'd1 : 64'd0);
            chk({tag, "/sofpos0"}, 64'(sof_bad), 64'd0);
            chk({tag, "/src0"}, 64'(src[0]), 64'(exp_src));
            chk({tag, "/type0"}, 64'(typ[0]), 64'(exp_type));
        end else begin
            chk({tag, "/done0"}, 64'(done_cnt[0]), 64'd0);
            chk({tag, "/en0"}, 64'(en_cnt[0]), 64'd0);
        end
        if (exp_acc1) begin
            chk({tag, "/done1"}, 64'(done_cnt[1]), 64'd1);
            chk({tag, "/err1"}, 64'(err_l[1]), 64'(exp_bad));
        end else begin
            chk({tag, "/done1"}, 64'(done_cnt[1]), 64'd0);
            chk({tag, "/en1"}, 64'(en_cnt[1]), 64'd0);
        end
        if (exp_acc0 && exp_len <= 64) begin
            chk({tag, "/done2"}, 64'(done_cnt[2]), 64'd1);
            chk({tag, "/drop2"}, 64'(drop_cnt[2]), 64'd0);
            chk({tag, "/num2"}, 64'(num_l[2]), 64'(exp_n));
        end else if (exp_acc0) begin
            chk({tag, "/done2"}, 64'(done_cnt[2]), 64'd0);
            chk({tag, "/drop2"}, 64'(drop_cnt[2]), 64'd1);
        end else begin
            chk({tag, "/done2"}, 64'(done_cnt[2]), 64'd0);
            chk({tag, "/drop2"}, 64'(drop_cnt[2]), 64'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/ctl"}, 64'({en[0], sof[0], done[0], err[0], drop[0], data[0], num[0], typ[0]}), 64'd0);
        chk({tag, "/src"}, 64'(src[0]), 64'd0);
    endtask

    initial begin
        idle(3);
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        clear_mon();
        build(7, BOARD, 16'h0800, 46, 1'b1, 1'b0);
        send(6);
        check_frame("unicast");

        clear_mon();
        build(7, BOARD, 16'h0800, 46, 1'b1, 1'b1);
        send(6);
        check_frame("bad_fcs");

        clear_mon();
        build(7, OTHER, 16'h0800, 46, 1'b1, 1'b0);
        send(6);
        check_frame("other_dest");

        clear_mon();
        build(7, BCAST, 16'h0806, 28, 1'b0, 1'b0);
        send(6);
        check_frame("bcast");

        // Short preamble, then a frame cut in its header, then a good frame, 1-cycle gaps
        clear_mon();
        build(3, BOARD, 16'h0800, 20, 1'b0, 1'b0);
        send(1);
        build(7, BOARD, 16'h0800, 20, 1'b0, 1'b0);
        while (tx_q.size() > 16) void'(tx_q.pop_back());
        send(1);
        build(7, BOARD, 16'h0806, 30, 1'b0, 1'b0);
        send(6);
        check_frame("gap_recover");

        // Oversize for the MAX_LEN=64 instance, followed by a good frame after a 1-cycle gap
        clear_mon();
        build(7, BOARD, 16'h0800, 82, 1'b0, 1'b0);
        send(1);
        build(8, BOARD, 16'h0800, 40, 1'b0, 1'b0);
        send(6);
        chk("maxlen/drop2", 64'(drop_cnt[2]), 64'd1);
        chk("maxlen/done2", 64'(done_cnt[2]), 64'd1);
        chk("maxlen/num2", 64'(num_l[2]), 64'd40);
        chk("maxlen/err2", 64'(err_l[2]), 64'd0);
        chk("maxlen/done0", 64'(done_cnt[0]), 64'd2);
        chk("maxlen/num0", 64'(num_l[0]), 64'd40);
        chk("maxlen/en0", 64'(en_cnt[0]), 64'd122);
        chk("maxlen/drop0", 64'(drop_cnt[0]), 64'd0);

        // Only two bytes after the header
        clear_mon();
        build(7, BOARD, 16'h0800, 0, 1'b0, 1'b0);
        void'(tx_q.pop_back());
        void'(tx_q.pop_back());
        send(6);
        chk("runt/done0", 64'(done_cnt[0]), 64'd1);
        chk("runt/num0", 64'(num_l[0]), 64'd0);
        chk("runt/err0", 64'(err_l[0]), 64'd1);
        chk("runt/en0", 64'(en_cnt[0]), 64'd0);

        // Reset while payload byte 20 is on the wire
        clear_mon();
        build(7, BOARD, 16'h0800, 30, 1'b1, 1'b0);
        for (int i = 0; i < 42; i++) drive_byte(1'b1, tx_q[i]);
        @(posedge clk);
        #1;
        gmii_rxd = tx_q[42];
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gmii_rxd = tx_q[43];
        clear_mon();
        for (int i = 44; i < tx_q.size(); i++) drive_byte(1'b1, tx_q[i]);
        idle(6);
        chk("mid_reset/en0", 64'(en_cnt[0]), 64'd0);
        chk("mid_reset/done0", 64'(done_cnt[0]), 64'd0);
        clear_mon();
        build(7, BOARD, 16'h0800, 33, 1'b0, 1'b0);
        send(6);
        check_frame("post_reset");

        for (int r = 0; r < 10; r++) begin
            logic [47:0] d;
            case ($urandom_range(0, 3))
                0:       d = OTHER;
                1:       d = BCAST;
                default: d = BOARD;
            endcase
            clear_mon();
            build(int'($urandom_range(6, 8)), d, 16'($urandom), int'($urandom_range(0, 70)),
                  1'b0, 1'($urandom_range(0, 1)));
            send(int'($urandom_range(6, 9)));
            check_frame($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
